// File: rtl/cpu_pkg.sv
// Shared CPU widths and the {instr, pc} fetch bundle handed from fetch to decode.
package cpu_pkg;

  localparam int INSTR_W = 32;
  localparam int PC_W    = 32;
  localparam logic [PC_W-1:0] PC_STEP = 32'd4;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } fetch_bundle_t;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO with registered storage, head read combinationally, synchronous flush.
// Push into a full FIFO without a pop is illegal; a pop of an empty FIFO is ignored.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_push,
  input  logic [WIDTH-1:0]       i_dat,
  input  logic                   i_pop,
  input  logic                   i_flush,
  output logic [WIDTH-1:0]       o_head_dat,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    r_wr_ptr;
  logic [AW:0]      r_count;
  logic             w_do_pop;

  assign w_do_pop   = i_pop && (r_count != '0);
  assign o_head_dat = r_mem[r_rd_ptr];
  assign o_count    = r_count;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_dat;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({i_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst && !i_flush)
      assert (!(i_push && !w_do_pop && r_count == FULL));
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch front end: owns the PC, issues to a 1-cycle registered imem, buffers words for decode.
// Issue-to-out_valid is 2 cycles; issue stalls once buffered + in-flight words reach FIFO_DEPTH.
module instruction_fetch
  import cpu_pkg::*;
#(
  parameter logic [PC_W-1:0] RESET_PC   = 32'h0000_0000,
  parameter int              FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               reset,
  output logic [PC_W-1:0]    imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc,
  input  logic               redirect_valid,
  input  logic [PC_W-1:0]    redirect_pc
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [PC_W-1:0] r_pc;
  logic [PC_W-1:0] r_inflight_pc;
  logic            r_inflight;

  logic [CW-1:0]   w_count;
  logic [CW:0]     w_occupancy;
  logic            w_pop;
  logic            w_issue;
  logic            w_push;
  logic [PC_W-1:0] w_redirect_base;
  fetch_bundle_t   w_push_dat;
  fetch_bundle_t   w_head;

  assign w_pop           = out_valid & out_ready;
  // A pop implies count >= 1, so this never underflows.
  assign w_occupancy     = {1'b0, w_count} + (CW+1)'(r_inflight) - (CW+1)'(w_pop);
  assign w_issue         = !redirect_valid && (w_occupancy < (CW+1)'(FIFO_DEPTH));
  assign w_push          = r_inflight && !redirect_valid;
  assign w_redirect_base = redirect_pc & ~(PC_W'(3));
  assign w_push_dat      = '{instr: imem_data, pc: r_inflight_pc};

  assign imem_addr = {2'b00, r_pc[PC_W-1:2]};
  assign out_valid = (w_count != '0);
  assign out_instr = w_head.instr;
  assign out_pc    = w_head.pc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pc          <= RESET_PC;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
    end else if (redirect_valid) begin
      r_pc       <= w_redirect_base;
      r_inflight <= 1'b0;
    end else if (w_issue) begin
      r_pc          <= r_pc + PC_STEP;
      r_inflight    <= 1'b1;
      r_inflight_pc <= r_pc;
    end else begin
      r_inflight <= 1'b0;
    end
  end

  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(fetch_bundle_t))
  ) u_fifo (
    .i_clk      (clk),
    .i_rst      (reset),
    .i_push     (w_push),
    .i_dat      (w_push_dat),
    .i_pop      (w_pop),
    .i_flush    (redirect_valid),
    .o_head_dat (w_head),
    .o_count    (w_count)
  );

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed tables, hand sequences, random traffic vs a stream model.
module tb_instruction_fetch;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic [31:0] imem_addr, imem_data, out_instr, out_pc, redirect_pc;
  logic        out_valid, out_ready, redirect_valid;

  logic [31:0] w_addr, w_data, w_instr, w_pc;
  logic        w_valid;

  int tests = 0;
  int fails = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h0BAD_F00D;
  endfunction

  // Behavioural instruction memory: one-cycle registered read.
  always @(posedge clk) begin
    imem_data <= mem_word(imem_addr);
    w_data    <= mem_word(w_addr);
  end

  instruction_fetch #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
    .clk(clk), .reset(reset), .imem_addr(imem_addr), .imem_data(imem_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc)
  );

  instruction_fetch #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(2)) dut_wrap (
    .clk(clk), .reset(reset), .imem_addr(w_addr), .imem_data(w_data),
    .out_valid(w_valid), .out_ready(1'b1), .out_instr(w_instr), .out_pc(w_pc),
    .redirect_valid(1'b0), .redirect_pc(32'h0)
  );

  typedef struct {
    logic [31:0] addr;
    logic        vld;
    logic [31:0] pc;
  } wrap_row_t;

  typedef struct {
    logic [31:0] rpc;
    logic [31:0] exp_first;
    int          stall;
    bit          rdy;
  } redir_vec_t;

  wrap_row_t  wrap_tab [5];
  redir_vec_t vt [6];

  // Stream model: next pc expected at the head, and how many empty cycles must precede it.
  logic [31:0] exp_pc;
  int          gap;
  bit          want_valid;
  bit          prev_stall;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic restart(input logic [31:0] rst_pc);
    exp_pc     = rst_pc;
    gap        = 2;
    want_valid = 0;
    prev_stall = 0;
  endtask

  task automatic observe();
    if (gap > 0) begin
      chk("bubble_valid", out_valid, 0);
      gap--;
      want_valid = (gap == 0);
    end else if (want_valid || prev_stall) begin
      chk("valid_expected", out_valid, 1);
      want_valid = 0;
    end
    if (out_valid) begin
      chk("stream_pc", out_pc, exp_pc);
      chk("stream_instr", out_instr, mem_word(exp_pc >> 2));
    end
  endtask

  task automatic tick(input bit rdy, input bit rv, input logic [31:0] rpc);
    observe();
    out_ready      = rdy;
    redirect_valid = rv;
    redirect_pc    = rpc;
    prev_stall     = out_valid && !rdy && !rv;
    if (rv) begin
      exp_pc     = rpc & 32'hFFFF_FFFC;
      gap        = 2;
      want_valid = 0;
    end else if (out_valid && rdy) begin
      exp_pc = exp_pc + 32'd4;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    wrap_tab[0] = '{32'h3FFF_FFFE, 1'b0, 32'h0};
    wrap_tab[1] = '{32'h3FFF_FFFF, 1'b0, 32'h0};
    wrap_tab[2] = '{32'h0000_0000, 1'b1, 32'hFFFF_FFF8};
    wrap_tab[3] = '{32'h0000_0001, 1'b1, 32'hFFFF_FFFC};
    wrap_tab[4] = '{32'h0000_0002, 1'b1, 32'h0000_0000};

    vt[0] = '{32'h0000_0040, 32'h0000_0040, 0, 1'b1};
    vt[1] = '{32'h0000_0023, 32'h0000_0020, 0, 1'b1};
    vt[2] = '{32'h0000_0023, 32'h0000_0020, 4, 1'b0};
    vt[3] = '{32'h8000_0002, 32'h8000_0000, 1, 1'b1};
    vt[4] = '{32'hFFFF_FFFF, 32'hFFFF_FFFC, 0, 1'b1};
    vt[5] = '{32'h0000_0101, 32'h0000_0100, 3, 1'b0};

    reset = 1'b1; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", out_valid, 0);
    chk("rst_instr", out_instr, 0);
    chk("rst_pc", out_pc, 0);
    chk("rst_imem_addr", imem_addr, 0);
    chk("rst_wrap_addr", w_addr, 32'h3FFF_FFFE);
    chk("rst_wrap_valid", w_valid, 0);

    // Release reset: straight stream of 42 words, plus the wrapping instance alongside.
    reset = 1'b0;
    restart(32'h0);
    for (int c = 0; c < 44; c++) begin
      if (c < 5) begin
        chk("wrap_addr", w_addr, wrap_tab[c].addr);
        chk("wrap_valid", w_valid, wrap_tab[c].vld);
        if (wrap_tab[c].vld) begin
          chk("wrap_pc", w_pc, wrap_tab[c].pc);
          chk("wrap_instr", w_instr, mem_word(wrap_tab[c].pc >> 2));
        end
      end
      if (c >= 2) begin
        chk("seq_valid", out_valid, 1);
        chk("seq_pc", out_pc, 32'(c - 2) * 32'd4);
      end
      tick(1, 0, 32'h0);
    end

    // Backpressure: stall 5 cycles with 0x10 at the head.
    tick(1, 1, 32'h0);
    for (int k = 0; k < 12 && !(out_valid && out_pc == 32'h10); k++) tick(1, 0, 32'h0);
    chk("bp_head_pc", out_pc, 32'h10);
    for (int s = 0; s < 5; s++) begin
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_pc", out_pc, 32'h10);
      chk("bp_hold_instr", out_instr, mem_word(32'h4));
      tick(0, 0, 32'h0);
    end
    chk("bp_issue_limit_addr", imem_addr, 32'h6);
    for (int s = 0; s < 8; s++) begin
      chk("bp_resume_valid", out_valid, 1);
      chk("bp_resume_pc", out_pc, 32'h10 + 32'(s) * 32'd4);
      tick(1, 0, 32'h0);
    end

    // Redirect vectors.
    for (int v = 0; v < 6; v++) begin
      repeat (3) tick(1, 0, 32'h0);
      repeat (vt[v].stall) tick(0, 0, 32'h0);
      tick(vt[v].rdy, 1, vt[v].rpc);
      chk("redir_r1_valid", out_valid, 0);
      tick(vt[v].rdy, 0, 32'h0);
      chk("redir_r2_valid", out_valid, 0);
      tick(vt[v].rdy, 0, 32'h0);
      chk("redir_first_valid", out_valid, 1);
      chk("redir_first_pc", out_pc, vt[v].exp_first);
      chk("redir_first_instr", out_instr, mem_word(vt[v].exp_first >> 2));
      repeat (4) tick(1, 0, 32'h0);
    end

    // Back-to-back redirects: the second one wins.
    tick(1, 1, 32'h0000_0100);
    tick(1, 1, 32'h0000_0200);
    tick(1, 0, 32'h0);
    tick(1, 0, 32'h0);
    chk("b2b_valid", out_valid, 1);
    chk("b2b_pc", out_pc, 32'h0000_0200);
    repeat (3) tick(1, 0, 32'h0);

    // Random traffic against the stream model.
    for (int k = 0; k < 1500; k++)
      tick($urandom_range(0, 3) != 0, $urandom_range(0, 24) == 0, $urandom());

    // Asynchronous reset between edges while streaming.
    repeat (6) tick(1, 0, 32'h0);
    @(posedge clk);
    #1;
    chk("pre_async_valid", out_valid, 1);
    #1 reset = 1'b1;
    #1;
    chk("async_valid", out_valid, 0);
    chk("async_imem_addr", imem_addr, 0);
    chk("async_pc", out_pc, 0);
    chk("async_instr", out_instr, 0);
    @(negedge clk);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    restart(32'h0);
    tick(1, 0, 32'h0);
    tick(1, 0, 32'h0);
    chk("post_rst_valid", out_valid, 1);
    chk("post_rst_pc", out_pc, 32'h0);
    repeat (6) tick(1, 0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
